snn_image_loader: RTL and testbench

- Parametrised, double-buffered image ingest stage between the host word stream and the SNN core (train_test_classify datapath).
- Packs incoming pixel words into one of two banks and latches mode and label per bank.
- Starts the core on a full bank; the core reads pixels randomly while the next image streams into the other bank.
- Replaces the single-buffer start_main/valid_image flow, where the host had to wait for valid_all before sending the next image.

---
 rtl/snn_image_loader.sv | 193 +++++++++++++++++++
 tb/tb_snn_image_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_image_loader.sv
// Double-buffered pixel-word ingest between the host stream and the SNN core.
// Optional macro PIXEL_SUM_EN adds img_sum, the pixel sum of the active bank.
module snn_image_loader #(
  parameter int M     = 784,
  parameter int PIX_W = 8,
  parameter int PPW   = 4,
  parameter int LBL_W = 8,
  localparam int WORD_W = PIX_W * PPW,
  localparam int WPI    = (M + PPW - 1) / PPW,
  localparam int AW     = $clog2(M)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_main,
  input  logic [1:0]         mode_in,
  input  logic [LBL_W-1:0]   label_in,
  input  logic [WORD_W-1:0]  image_in,
  input  logic               valid_image,
  output logic               image_ready,
  output logic               arm_ready,
  output logic               start_core_img,
  output logic [1:0]         core_mode,
  output logic [LBL_W-1:0]   core_label,
  output logic               core_busy,
  input  logic [AW-1:0]      rd_addr,
  output logic [PIX_W-1:0]   rd_data,
  input  logic               core_done,
  output logic               err_sticky
`ifdef PIXEL_SUM_EN
  ,
  output logic [PIX_W+AW-1:0] img_sum
`endif
);

  localparam int CW  = (WPI > 1) ? $clog2(WPI) : 1;
  localparam int MAW = $clog2(2 * WPI);
  localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_ACTIVE} bank_t;
  typedef enum logic {W_IDLE, W_FILL} wst_t;
  typedef enum logic {R_IDLE, R_BUSY} rst_t;

  bank_t              bank_q [2];
  logic [1:0]         mode_q [2];
  logic [LBL_W-1:0]   label_q [2];
  wst_t               wstate_q;
  rst_t               rstate_q;
  logic [CW-1:0]      wcnt_q;
  logic               wr_bank_q, rd_bank_q, older_q, live_q;
  logic               start_q, busy_q, err_q;
  logic [1:0]         cmode_q;
  logic [LBL_W-1:0]   clabel_q;
  logic [PIX_W-1:0]   rd_data_q;
  logic [WORD_W-1:0]  mem_q [2*WPI];

  logic               any_free, free_idx, any_full, pick;
  logic               arm_go, acc_go, last_go, start_go;
  logic [MAW-1:0]     waddr, raddr;
  logic [LW-1:0]      rsel;
  logic [WORD_W-1:0]  rword;
  logic [PIX_W-1:0]   rpix;

  assign any_free = (bank_q[0] == B_FREE) || (bank_q[1] == B_FREE);
  assign free_idx = (bank_q[0] == B_FREE) ? 1'b0 : 1'b1;
  assign any_full = (bank_q[0] == B_FULL) || (bank_q[1] == B_FULL);
  // With both banks full, the one that completed first goes to the core.
  assign pick     = (bank_q[0] == B_FULL && bank_q[1] == B_FULL) ? older_q
                                                                   : (bank_q[1] == B_FULL);

  assign arm_ready = live_q && (wstate_q == W_IDLE) && any_free;
  assign arm_go    = (wstate_q == W_IDLE) && start_main && arm_ready;
  assign acc_go    = (wstate_q == W_FILL) && valid_image;
  assign last_go   = acc_go && (wcnt_q == CW'(WPI - 1));
  assign start_go  = (rstate_q == R_IDLE) && any_full;

  assign image_ready    = (wstate_q == W_FILL);
  assign start_core_img = start_q;
  assign core_busy      = busy_q;
  assign core_mode      = cmode_q;
  assign core_label     = clabel_q;
  assign err_sticky     = err_q;
  assign rd_data        = rd_data_q;

  assign waddr = MAW'((wr_bank_q ? WPI : 0) + int'(wcnt_q));
  assign raddr = MAW'((rd_bank_q ? WPI : 0) + int'(rd_addr) / PPW);
  assign rsel  = LW'(int'(rd_addr) % PPW);
  assign rword = mem_q[raddr];
  assign rpix  = rword[int'(rsel)*PIX_W +: PIX_W];

  always_ff @(posedge clk) begin
    if (acc_go) mem_q[waddr] <= image_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else if (rstate_q == R_BUSY && int'(rd_addr) < M) rd_data_q <= rpix;
    else rd_data_q <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b]  <= B_FREE;
        mode_q[b]  <= '0;
        label_q[b] <= '0;
      end
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wcnt_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      older_q   <= 1'b0;
      live_q    <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cmode_q   <= '0;
      clabel_q  <= '0;
    end else begin
      live_q  <= 1'b1;
      start_q <= 1'b0;
      // Fill side: the two sides never touch the same bank in one cycle.
      if (wstate_q == W_IDLE) begin
        if (arm_go) begin
          bank_q[free_idx]  <= B_FILLING;
          mode_q[free_idx]  <= mode_in;
          label_q[free_idx] <= label_in;
          wr_bank_q         <= free_idx;
          wcnt_q            <= '0;
          wstate_q          <= W_FILL;
        end else if (start_main) begin
          err_q <= 1'b1;
        end
      end else begin
        if (start_main) err_q <= 1'b1;
        if (last_go) begin
          bank_q[wr_bank_q] <= B_FULL;
          wstate_q          <= W_IDLE;
          if (bank_q[~wr_bank_q] != B_FULL) older_q <= wr_bank_q;
        end else if (acc_go) begin
          wcnt_q <= wcnt_q + CW'(1);
        end
      end
      // Read side
      if (rstate_q == R_IDLE) begin
        if (core_done) err_q <= 1'b1;
        if (start_go) begin
          bank_q[pick] <= B_ACTIVE;
          rd_bank_q    <= pick;
          cmode_q      <= mode_q[pick];
          clabel_q     <= label_q[pick];
          start_q      <= 1'b1;
          busy_q       <= 1'b1;
          rstate_q     <= R_BUSY;
        end
      end else if (core_done) begin
        bank_q[rd_bank_q] <= B_FREE;
        busy_q            <= 1'b0;
        rstate_q          <= R_IDLE;
      end
    end
  end

`ifdef PIXEL_SUM_EN
  localparam int SW = PIX_W + AW;
  logic [SW-1:0] sum_q [2];
  logic [SW-1:0] img_sum_q;
  logic [SW-1:0] word_sum;

  // Padding lanes past pixel M-1 in the last word never reach the sum.
  always_comb begin
    word_sum = '0;
    for (int k = 0; k < PPW; k++) begin
      if (int'(wcnt_q) * PPW + k < M) word_sum = word_sum + SW'(image_in[k*PIX_W +: PIX_W]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q[0]  <= '0;
      sum_q[1]  <= '0;
      img_sum_q <= '0;
    end else begin
      if (arm_go) sum_q[free_idx] <= '0;
      else if (acc_go) sum_q[wr_bank_q] <= sum_q[wr_bank_q] + word_sum;
      if (start_go) img_sum_q <= sum_q[pick];
    end
  end

  assign img_sum = img_sum_q;
`endif

endmodule

// File: tb/tb_snn_image_loader.sv
// Scoreboard bench for snn_image_loader: a default 784-pixel instance plus a
// 10-pixel instance that exercises the padded last word.
`timescale 1ns/1ps
module tb_snn_image_loader;
  localparam int M = 784, PIX_W = 8, PPW = 4, LBL_W = 8, WPI = 196, AW = 10;
  localparam int SM = 10, SAW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_main, valid_image, core_done;
  logic [1:0]        mode_in;
  logic [LBL_W-1:0]  label_in;
  logic [31:0]       image_in;
  logic [AW-1:0]     rd_addr;
  logic              image_ready, arm_ready, start_core_img, core_busy, err_sticky;
  logic [1:0]        core_mode;
  logic [LBL_W-1:0]  core_label;
  logic [PIX_W-1:0]  rd_data;

  logic              s_start, s_valid, s_done;
  logic [31:0]       s_image;
  logic [SAW-1:0]    s_rd_addr;
  logic              s_ready, s_arm, s_startc, s_busy, s_err;
  logic [1:0]        s_mode;
  logic [LBL_W-1:0]  s_label;
  logic [PIX_W-1:0]  s_rd_data;
`ifdef PIXEL_SUM_EN
  logic [PIX_W+AW-1:0]  img_sum;
  logic [PIX_W+SAW-1:0] s_img_sum;
`endif

  always #5 clk = ~clk;

  snn_image_loader #(.M(M), .PIX_W(PIX_W), .PPW(PPW), .LBL_W(LBL_W)) u_dut (
    .clk(clk), .rst(rst), .start_main(start_main), .mode_in(mode_in), .label_in(label_in),
    .image_in(image_in), .valid_image(valid_image), .image_ready(image_ready),
    .arm_ready(arm_ready), .start_core_img(start_core_img), .core_mode(core_mode),
    .core_label(core_label), .core_busy(core_busy), .rd_addr(rd_addr), .rd_data(rd_data),
    .core_done(core_done), .err_sticky(err_sticky)
`ifdef PIXEL_SUM_EN
    , .img_sum(img_sum)
`endif
  );

  snn_image_loader #(.M(SM), .PIX_W(PIX_W), .PPW(PPW), .LBL_W(LBL_W)) u_small (
    .clk(clk), .rst(rst), .start_main(s_start), .mode_in(2'd2), .label_in(8'd6),
    .image_in(s_image), .valid_image(s_valid), .image_ready(s_ready),
    .arm_ready(s_arm), .start_core_img(s_startc), .core_mode(s_mode),
    .core_label(s_label), .core_busy(s_busy), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .core_done(s_done), .err_sticky(s_err)
`ifdef PIXEL_SUM_EN
    , .img_sum(s_img_sum)
`endif
  );

  int n_vec = 0, n_bad = 0, n_acc = 0, n_start = 0;
  logic [31:0] rd_q[$];
  logic [31:0] st_q[$];
  logic rd_req = 1'b0, rd_req_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int sel, input int p);
    return (sel == 0) ? 8'(p % 256) : 8'((p * 3 + 1) % 256);
  endfunction

  always @(posedge clk) begin
    rd_req_d <= rd_req;
    if (rst && valid_image && image_ready) n_acc++;
  end

  always @(negedge clk) begin
    if (rd_req_d) begin
      chk("rd_pending", 32'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) chk("rd_data", 32'(rd_data), rd_q.pop_front());
    end
    if (start_core_img) begin
      n_start++;
      chk("start_pending", 32'(st_q.size() > 0), 1);
      if (st_q.size() > 0) chk("start_mode_label", 32'({core_mode, core_label}), st_q.pop_front());
    end
  end

  task automatic rd(input int a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = AW'(a);
    rd_req = 1'b1;
    rd_q.push_back(32'(e));
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic arm(input logic [1:0] md, input logic [7:0] lb);
    @(negedge clk);
    start_main = 1'b1; mode_in = md; label_in = lb;
    @(negedge clk);
    start_main = 1'b0;
  endtask

  task automatic feed(input int sel, input int w0, input int w1, input bit toggle);
    int w, budget;
    w = w0; budget = 0;
    while (w < w1 && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (image_ready && !(toggle && (budget % 2 == 0))) begin
        for (int k = 0; k < PPW; k++) image_in[k*PIX_W +: PIX_W] = pix(sel, w * PPW + k);
        valid_image = 1'b1;
        w++;
      end else begin
        valid_image = 1'b0;
      end
    end
    @(negedge clk);
    valid_image = 1'b0;
    if (w < w1) chk("feed_timeout", 32'(w), 32'(w1));
  endtask

  task automatic release_core();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, s0, wi;
    rst = 1'b0; start_main = 1'b0; valid_image = 1'b0; core_done = 1'b0;
    mode_in = '0; label_in = '0; image_in = '0; rd_addr = '0;
    s_start = 1'b0; s_valid = 1'b0; s_done = 1'b0; s_image = '0; s_rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_image_ready", 32'(image_ready), 0);
    chk("rst_arm_ready", 32'(arm_ready), 0);
    chk("rst_busy", 32'(core_busy), 0);
    chk("rst_err", 32'(err_sticky), 0);
    chk("rst_start", 32'(start_core_img), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("arm_ready_idle", 32'(arm_ready), 1);

    // Stray core_done with no bank active
    release_core();
    chk("err_core_done_idle", 32'(err_sticky), 1);
    chk("busy_after_stray_done", 32'(core_busy), 0);
    chk("arm_after_stray_done", 32'(arm_ready), 1);
    #2 rst = 1'b0;
    #1 chk("err_cleared_by_rst", 32'(err_sticky), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    // Image A: ramp, mode 1, label 0
    st_q.push_back(32'({2'd1, 8'd0}));
    n0 = n_acc;
    arm(2'd1, 8'd0);
    feed(0, 0, WPI, 1'b0);
    chk("img_ready_low_after_last", 32'(image_ready), 0);
    chk("no_start_before_latency", 32'(start_core_img), 0);
    @(negedge clk);
    chk("start_latency2", 32'(start_core_img), 1);
    chk("core_busy_A", 32'(core_busy), 1);
    chk("acc_count_A", 32'(n_acc - n0), 196);
    chk("core_mode_A", 32'(core_mode), 1);
`ifdef PIXEL_SUM_EN
    chk("img_sum_A", 32'(img_sum), 98040);
`endif
    rd(0, 8'd0); rd(5, 8'd5); rd(783, 8'd15); rd(784, 8'd0); rd(1023, 8'd0);

    // Image B streams while A is held by the core
    st_q.push_back(32'({2'd2, 8'd3}));
    n0 = n_acc; s0 = n_start;
    arm(2'd2, 8'd3);
    feed(1, 0, WPI, 1'b1);
    chk("acc_count_B_toggle", 32'(n_acc - n0), 196);
    chk("arm_ready_no_free", 32'(arm_ready), 0);
    image_in = 32'hDEADBEEF;
    valid_image = 1'b1;
    repeat (5) @(negedge clk);
    valid_image = 1'b0;
    chk("no_accept_outside_fill", 32'(n_acc - n0), 196);
    repeat (5) @(negedge clk);
    chk("no_second_start", 32'(n_start - s0), 0);
    chk("label_A_held", 32'(core_label), 0);
    rd(783, 8'd15);
    release_core();
    chk("busy_fell", 32'(core_busy), 0);
    @(negedge clk);
    chk("start_B", 32'(start_core_img), 1);
    chk("label_B", 32'(core_label), 3);
    rd(7, pix(1, 7)); rd(783, pix(1, 783));

    // Image C with a stray start_main mid-fill
    st_q.push_back(32'({2'd3, 8'h55}));
    n0 = n_acc;
    arm(2'd3, 8'h55);
    feed(0, 0, 20, 1'b0);
    @(negedge clk) start_main = 1'b1;
    @(negedge clk) start_main = 1'b0;
    chk("err_start_in_fill", 32'(err_sticky), 1);
    chk("img_ready_during_fill", 32'(image_ready), 1);
    feed(0, 20, WPI, 1'b0);
    chk("img_ready_low_C", 32'(image_ready), 0);
    chk("acc_count_C", 32'(n_acc - n0), 196);
    release_core();
    @(negedge clk);
    chk("start_C", 32'(start_core_img), 1);
    rd(100, 8'd100);

    // Asynchronous reset mid-fill while C is held by the core
    arm(2'd1, 8'd9);
    feed(1, 0, 50, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_image_ready", 32'(image_ready), 0);
    chk("mid_rst_arm_ready", 32'(arm_ready), 0);
    chk("mid_rst_busy", 32'(core_busy), 0);
    chk("mid_rst_err", 32'(err_sticky), 0);
    chk("mid_rst_label", 32'(core_label), 0);
    chk("mid_rst_mode", 32'(core_mode), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    st_q.push_back(32'({2'd1, 8'd7}));
    n0 = n_acc;
    arm(2'd1, 8'd7);
    feed(0, 0, WPI, 1'b0);
    @(negedge clk);
    chk("start_after_rst", 32'(start_core_img), 1);
    chk("acc_count_after_rst", 32'(n_acc - n0), 196);
    rd(1, 8'd1); rd(783, 8'd15);
    release_core();

    // Small instance: 10 pixels, last word carries two padding lanes
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    wi = 0;
    for (int c = 0; c < 50 && wi < 3; c++) begin
      @(negedge clk);
      if (s_ready) begin
        s_image = (wi == 2) ? 32'hFFFF0A09 : {8'(wi*4+4), 8'(wi*4+3), 8'(wi*4+2), 8'(wi*4+1)};
        s_valid = 1'b1;
        wi++;
      end else s_valid = 1'b0;
    end
    @(negedge clk) s_valid = 1'b0;
    for (int c = 0; c < 10 && !s_busy; c++) @(negedge clk);
    chk("s_busy", 32'(s_busy), 1);
    chk("s_label", 32'(s_label), 6);
    s_rd_addr = 4'd9;  @(negedge clk); chk("s_rd9", 32'(s_rd_data), 10);
    s_rd_addr = 4'd10; @(negedge clk); chk("s_rd10_pad", 32'(s_rd_data), 0);
    s_rd_addr = 4'd11; @(negedge clk); chk("s_rd11_pad", 32'(s_rd_data), 0);
    s_rd_addr = 4'd0;  @(negedge clk); chk("s_rd0", 32'(s_rd_data), 1);
`ifdef PIXEL_SUM_EN
    chk("s_img_sum", 32'(s_img_sum), 55);
`endif

    repeat (3) @(negedge clk);
    chk("start_q_drained", 32'(st_q.size()), 0);
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
